// File: rtl/mode7_pkg.sv
// Shared definitions for the mode-7 coordinate generator.
//   FRAC_BITS / TRIG_FRAC : binary points of the 16.8 parameters and the Q2.14 trig values
//   fx_t                  : 24-bit signed 16.8 fixed-point value
//   state_e               : sequencer states of the coordinate generator
//   trig_coef()           : (scale * trig) >>> TRIG_FRAC, truncated to 16.8, optionally negated
package mode7_pkg;

  localparam int FRAC_BITS = 8;
  localparam int TRIG_FRAC = 14;

  typedef logic signed [23:0] fx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIG   = 3'd1,
    MATRIX = 3'd2,
    LINE   = 3'd3,
    RUN    = 3'd4
  } state_e;

  // Rotate/scale matrix coefficient. The negation is applied to the full
  // product before the shift so that -s*t rounds the same way as s*(-t).
  function automatic fx_t trig_coef(input fx_t s, input logic signed [15:0] t, input logic neg);
    logic signed [39:0] prod;
    prod = s * t;
    prod = neg ? -prod : prod;
    trig_coef = fx_t'(prod >>> TRIG_FRAC);
  endfunction

endpackage

// File: rtl/mode7_trig_lut.sv
// Synchronous 256-step sine/cosine ROM, one cycle read latency.
//   clk, reset : clock and asynchronous active-high reset (outputs clear to 0)
//   idx        : angle, 256 steps per revolution
//   sin_val    : signed Q2.14 sine of idx, registered
//   cos_val    : signed Q2.14 cosine of idx, registered
// Only the first quadrant (64 entries) is stored; the rest is mirrored.
module mode7_trig_lut
  import mode7_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         idx,
  output logic signed [15:0] sin_val,
  output logic signed [15:0] cos_val
);

  // Quarter-wave table: round(16384 * sin(k * pi / 128)), k = 0..63.
  function automatic logic [15:0] qwave(input logic [5:0] k);
    case (k)
      6'd0:  qwave = 16'd0;     6'd1:  qwave = 16'd402;   6'd2:  qwave = 16'd804;   6'd3:  qwave = 16'd1205;
      6'd4:  qwave = 16'd1606;  6'd5:  qwave = 16'd2006;  6'd6:  qwave = 16'd2404;  6'd7:  qwave = 16'd2801;
      6'd8:  qwave = 16'd3196;  6'd9:  qwave = 16'd3590;  6'd10: qwave = 16'd3981;  6'd11: qwave = 16'd4370;
      6'd12: qwave = 16'd4756;  6'd13: qwave = 16'd5139;  6'd14: qwave = 16'd5520;  6'd15: qwave = 16'd5897;
      6'd16: qwave = 16'd6270;  6'd17: qwave = 16'd6639;  6'd18: qwave = 16'd7005;  6'd19: qwave = 16'd7366;
      6'd20: qwave = 16'd7723;  6'd21: qwave = 16'd8076;  6'd22: qwave = 16'd8423;  6'd23: qwave = 16'd8765;
      6'd24: qwave = 16'd9102;  6'd25: qwave = 16'd9434;  6'd26: qwave = 16'd9760;  6'd27: qwave = 16'd10080;
      6'd28: qwave = 16'd10394; 6'd29: qwave = 16'd10702; 6'd30: qwave = 16'd11003; 6'd31: qwave = 16'd11297;
      6'd32: qwave = 16'd11585; 6'd33: qwave = 16'd11866; 6'd34: qwave = 16'd12140; 6'd35: qwave = 16'd12406;
      6'd36: qwave = 16'd12665; 6'd37: qwave = 16'd12916; 6'd38: qwave = 16'd13160; 6'd39: qwave = 16'd13395;
      6'd40: qwave = 16'd13623; 6'd41: qwave = 16'd13842; 6'd42: qwave = 16'd14053; 6'd43: qwave = 16'd14256;
      6'd44: qwave = 16'd14449; 6'd45: qwave = 16'd14635; 6'd46: qwave = 16'd14811; 6'd47: qwave = 16'd14978;
      6'd48: qwave = 16'd15137; 6'd49: qwave = 16'd15286; 6'd50: qwave = 16'd15426; 6'd51: qwave = 16'd15557;
      6'd52: qwave = 16'd15679; 6'd53: qwave = 16'd15791; 6'd54: qwave = 16'd15893; 6'd55: qwave = 16'd15986;
      6'd56: qwave = 16'd16069; 6'd57: qwave = 16'd16143; 6'd58: qwave = 16'd16207; 6'd59: qwave = 16'd16261;
      6'd60: qwave = 16'd16305; 6'd61: qwave = 16'd16340; 6'd62: qwave = 16'd16364; 6'd63: qwave = 16'd16379;
      default: qwave = 16'd0;
    endcase
  endfunction

  // Full-circle sine: odd quadrants read the table backwards (index 64 is
  // the peak, which the 64-entry table cannot hold), upper half negates.
  function automatic logic signed [15:0] sin_of(input logic [7:0] i);
    logic [6:0]  j;
    logic [15:0] mag;
    j   = i[6] ? (7'd64 - {1'b0, i[5:0]}) : {1'b0, i[5:0]};
    mag = (j == 7'd64) ? 16'd16384 : qwave(j[5:0]);
    sin_of = i[7] ? -$signed(mag) : $signed(mag);
  endfunction

  logic signed [15:0] sin_s;
  logic signed [15:0] cos_s;

  // ROM lookup; cosine is the sine a quarter turn ahead.
  always_comb begin
    sin_s = sin_of(idx);
    cos_s = sin_of(idx + 8'd64);
  end

  // Registered ROM read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sin_val <= 16'sd0;
      cos_val <= 16'sd0;
    end else begin
      sin_val <= sin_s;
      cos_val <= cos_s;
    end
  end

endmodule

// File: rtl/mode7_coord_gen.sv
// Mode-7 texture coordinate generator.
//   clk, reset            : clock, asynchronous active-high reset
//   frame_start           : one-cycle pulse, starts a frame when idle (ignored while busy)
//   offsetx/y, originx/y  : signed 16.8 scroll offset and rotation origin
//   texturew/h            : unsigned 16.8 texture size, power-of-two integer part
//   scalex/y              : signed 16.8 scale
//   angle                 : angle[15:8] = 256 steps per revolution
//   busy                  : frame in progress
//   out_valid/out_ready   : coordinate stream handshake
//   out_x, out_y          : raster position of the current coordinate
//   tex_u, tex_v          : wrapped integer texture coordinate
//   out_oob               : unwrapped coordinate lies outside the texture
//   frame_done            : one-cycle pulse after the last pixel is accepted
module mode7_coord_gen
  import mode7_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [23:0] offsetx,
  input  logic [23:0] offsety,
  input  logic [23:0] originx,
  input  logic [23:0] originy,
  input  logic [23:0] texturew,
  input  logic [23:0] textureh,
  input  logic [23:0] scalex,
  input  logic [23:0] scaley,
  input  logic [23:0] angle,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic [15:0] tex_u,
  output logic [15:0] tex_v,
  output logic        out_oob,
  output logic        frame_done
);

  state_e state_r;
  logic   phase_r;

  fx_t         offx_r, offy_r, orgx_r, orgy_r, scx_r, scy_r;
  logic [15:0] texw_r, texh_r;
  logic [7:0]  ang_r;

  fx_t                a_r, b_r, c_r, d_r;
  logic signed [47:0] p_ax_r, p_by_r, p_cx_r, p_dy_r;
  logic signed [ACC_W-1:0] u_r, v_r;
  logic [9:0]  x_r, y_r;

  logic        busy_r, valid_r, done_r, oob_r;
  logic [15:0] tu_r, tv_r;

  logic signed [15:0] sin_s, cos_s;

  logic        capture_s, hs_s, last_x_s, last_y_s, load_out_s;
  fx_t         x0_s, y0_s;
  logic signed [48:0] sum_u_s, sum_v_s, wide_u_s, wide_v_s;
  logic signed [ACC_W-1:0] line_u_s, line_v_s, nxt_u_s, nxt_v_s;
  logic [16:0] map_u_s, map_v_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{angle[23:16], angle[7:0], texturew[7:0], textureh[7:0]};

  mode7_trig_lut u_trig (
    .clk     (clk),
    .reset   (reset),
    .idx     (ang_r),
    .sin_val (sin_s),
    .cos_val (cos_s)
  );

  // Wrap mask and out-of-bounds flag for one axis; hi is the accumulator
  // without its fraction bits. A negative value also compares as huge.
  function automatic logic [16:0] map_axis(input logic [ACC_W-9:0] hi, input logic [15:0] dim);
    logic oob;
    oob = hi[ACC_W-9] || (hi >= (ACC_W-8)'(dim));
    map_axis = {oob, hi[15:0] & (dim - 16'd1)};
  endfunction

  // Handshake, raster position and per-line start/step arithmetic.
  always_comb begin
    capture_s = (state_r == IDLE) && frame_start;
    hs_s      = valid_r && out_ready;
    last_x_s  = (x_r == 10'(H_ACT - 1));
    last_y_s  = (y_r == 10'(V_ACT - 1));
    load_out_s = ((state_r == LINE) && phase_r) || ((state_r == RUN) && hs_s && !last_x_s);

    x0_s = offx_r - orgx_r;
    y0_s = $signed({6'd0, y_r, 8'd0}) + offy_r - orgy_r;

    sum_u_s  = p_ax_r + p_by_r;
    sum_v_s  = p_cx_r + p_dy_r;
    wide_u_s = (sum_u_s >>> FRAC_BITS) + orgx_r;
    wide_v_s = (sum_v_s >>> FRAC_BITS) + orgy_r;
    line_u_s = ACC_W'(wide_u_s);
    line_v_s = ACC_W'(wide_v_s);

    if (state_r == LINE) begin
      nxt_u_s = line_u_s;
      nxt_v_s = line_v_s;
    end else begin
      nxt_u_s = u_r + {{(ACC_W-24){a_r[23]}}, a_r};
      nxt_v_s = v_r + {{(ACC_W-24){c_r[23]}}, c_r};
    end

    map_u_s = map_axis(nxt_u_s[ACC_W-1:8], texw_r);
    map_v_s = map_axis(nxt_v_s[ACC_W-1:8], texh_r);
  end

  // Parameter snapshot, taken only when a frame is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offx_r <= 24'sd0; offy_r <= 24'sd0; orgx_r <= 24'sd0; orgy_r <= 24'sd0;
      scx_r  <= 24'sd0; scy_r  <= 24'sd0;
      texw_r <= 16'd0;  texh_r <= 16'd0;  ang_r  <= 8'd0;
    end else if (capture_s) begin
      offx_r <= $signed(offsetx); offy_r <= $signed(offsety);
      orgx_r <= $signed(originx); orgy_r <= $signed(originy);
      scx_r  <= $signed(scalex);  scy_r  <= $signed(scaley);
      texw_r <= texturew[23:8];   texh_r <= textureh[23:8];
      ang_r  <= angle[15:8];
    end
  end

  // Sequencer: frame/line control, raster counters and stream flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      phase_r <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      x_r     <= 10'd0;
      y_r     <= 10'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            state_r <= TRIG;
            busy_r  <= 1'b1;
            x_r     <= 10'd0;
            y_r     <= 10'd0;
          end
        end
        TRIG: begin
          state_r <= MATRIX;
          phase_r <= 1'b0;
        end
        MATRIX: begin
          phase_r <= ~phase_r;
          if (phase_r) begin
            state_r <= LINE;
          end
        end
        LINE: begin
          phase_r <= ~phase_r;
          if (phase_r) begin
            state_r <= RUN;
            valid_r <= 1'b1;
          end
        end
        RUN: begin
          if (hs_s) begin
            if (last_x_s) begin
              valid_r <= 1'b0;
              x_r     <= 10'd0;
              if (last_y_s) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                y_r     <= 10'd0;
              end else begin
                state_r <= LINE;
                y_r     <= y_r + 10'd1;
              end
            end else begin
              x_r <= x_r + 10'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          phase_r <= 1'b0;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: matrix coefficients, line-start products, accumulators and
  // the output data registers (loaded from the value entering the accumulators).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= 24'sd0; b_r <= 24'sd0; c_r <= 24'sd0; d_r <= 24'sd0;
      p_ax_r <= 48'sd0; p_by_r <= 48'sd0; p_cx_r <= 48'sd0; p_dy_r <= 48'sd0;
      u_r <= '0; v_r <= '0;
      tu_r <= 16'd0; tv_r <= 16'd0; oob_r <= 1'b0;
    end else begin
      if (state_r == MATRIX && !phase_r) begin
        a_r <= trig_coef(scx_r, cos_s, 1'b0);
        b_r <= trig_coef(scx_r, sin_s, 1'b0);
      end
      if (state_r == MATRIX && phase_r) begin
        c_r <= trig_coef(scy_r, sin_s, 1'b1);
        d_r <= trig_coef(scy_r, cos_s, 1'b0);
      end
      if (state_r == LINE && !phase_r) begin
        p_ax_r <= a_r * x0_s;
        p_by_r <= b_r * y0_s;
        p_cx_r <= c_r * x0_s;
        p_dy_r <= d_r * y0_s;
      end
      if (load_out_s) begin
        u_r   <= nxt_u_s;
        v_r   <= nxt_v_s;
        tu_r  <= map_u_s[15:0];
        tv_r  <= map_v_s[15:0];
        oob_r <= map_u_s[16] | map_v_s[16];
      end
    end
  end

  assign busy       = busy_r;
  assign out_valid  = valid_r;
  assign out_x      = x_r;
  assign out_y      = y_r;
  assign tex_u      = tu_r;
  assign tex_v      = tv_r;
  assign out_oob    = oob_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_mode7_coord_gen.sv
// Directed bench for mode7_coord_gen with a 4x3 raster.
module tb_mode7_coord_gen;

  localparam int H = 4;
  localparam int V = 3;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [23:0] offsetx = 24'd0, offsety = 24'd0, originx = 24'd0, originy = 24'd0;
  logic [23:0] texturew = 24'd0, textureh = 24'd0, scalex = 24'd0, scaley = 24'd0, angle = 24'd0;
  logic        out_ready = 1'b1;
  logic        busy, out_valid, out_oob, frame_done;
  logic [9:0]  out_x, out_y;
  logic [15:0] tex_u, tex_v;

  always #5 clk = ~clk;

  mode7_coord_gen #(.H_ACT(H), .V_ACT(V), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .offsetx(offsetx), .offsety(offsety), .originx(originx), .originy(originy),
    .texturew(texturew), .textureh(textureh), .scalex(scalex), .scaley(scaley), .angle(angle),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .tex_u(tex_u), .tex_v(tex_v),
    .out_oob(out_oob), .frame_done(frame_done)
  );

  int checks = 0;
  int failures = 0;

  logic [9:0]  bx [0:31];
  logic [9:0]  by [0:31];
  logic [15:0] bu [0:31];
  logic [15:0] bv [0:31];
  logic        boob [0:31];
  int          bcyc [0:31];
  int          nbeats, ndone, done_cyc, first_valid_cyc, stall_seen, stall_bad, timeout_hit, rst_cyc;
  logic        busy_first, busy_at_done, valid_at_done, rst_hit;
  logic [55:0] rst_vec;

  task automatic set_params(input logic [23:0] ox, oy, gx, gy, tw, th, sx, sy, ang);
    offsetx = ox; offsety = oy; originx = gx; originy = gy;
    texturew = tw; textureh = th; scalex = sx; scaley = sy; angle = ang;
  endtask

  // Starts a frame and records every accepted beat. Optional stall at
  // (stall_x,stall_y), retrigger cycle, reset at (rst_x,rst_y), input scramble.
  task automatic run_frame(input int stall_x, input int stall_y, input int stall_len,
                           input int retrig_cyc, input int rst_x, input int rst_y, input bit scramble);
    int c;
    int stall_left;
    bit snap_taken;
    logic [16:0] snap;
    logic r;
    nbeats = 0; ndone = 0; done_cyc = -1; first_valid_cyc = -1;
    stall_seen = 0; stall_bad = 0; timeout_hit = 0; rst_hit = 1'b0; rst_cyc = -1;
    busy_first = 1'b0; busy_at_done = 1'b1; valid_at_done = 1'b1; rst_vec = '1;
    stall_left = stall_len; snap_taken = 0; snap = '0;
    @(negedge clk); frame_start = 1'b1; out_ready = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    c = 0;
    while (1) begin
      if (c == 0) busy_first = busy;
      if (scramble && c == 0)
        set_params(24'h7F1200, 24'h034500, 24'h001100, 24'h002200, 24'h000100, 24'h000100,
                   24'hFF0000, 24'h000080, 24'h00A300);
      frame_start = (c == retrig_cyc);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (frame_done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c; busy_at_done = busy; valid_at_done = out_valid;
        end
      end
      if (!rst_hit && rst_x >= 0 && out_valid && out_x == 10'(rst_x) && out_y == 10'(rst_y)) begin
        reset = 1'b1;
        #1;
        rst_vec = {busy, out_valid, out_x, out_y, tex_u, tex_v, out_oob, frame_done, 6'd0};
        rst_hit = 1'b1; rst_cyc = c;
      end else if (!rst_hit) begin
        r = 1'b1;
        if (stall_len > 0 && out_valid && out_x == 10'(stall_x) && out_y == 10'(stall_y)) begin
          if (!snap_taken) begin
            snap = {out_oob, tex_u}; snap_taken = 1;
          end else if ({out_oob, tex_u} !== snap) begin
            stall_bad++;
          end
          if (stall_left > 0) begin
            r = 1'b0; stall_left--; stall_seen++;
          end
        end
        out_ready = r;
        if (out_valid && r && nbeats < 32) begin
          bx[nbeats] = out_x; by[nbeats] = out_y; bu[nbeats] = tex_u; bv[nbeats] = tex_v;
          boob[nbeats] = out_oob; bcyc[nbeats] = c; nbeats++;
        end
      end
      if (rst_hit && c >= rst_cyc + 5) break;
      if (done_cyc >= 0 && c >= done_cyc + 10) break;
      if (c >= 300) begin timeout_hit = 1; break; end
      @(negedge clk);
      c++;
    end
    frame_start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, out_x, out_y, tex_u, tex_v, out_oob, frame_done} !== 56'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {busy, out_valid, out_x, out_y, tex_u, tex_v, out_oob, frame_done});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid, frame_done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got busy/valid/done=%b want 000", {busy, out_valid, frame_done});
    end
  endtask

  task automatic test_identity;
    set_params(24'd0, 24'd0, 24'd0, 24'd0, 24'h004000, 24'h004000, 24'h000100, 24'h000100, 24'd0);
    run_frame(-1, -1, 0, -1, -1, -1, 1'b0);
    checks++;
    if (timeout_hit !== 0 || nbeats !== NPIX || ndone !== 1) begin
      failures++;
      $display("FAIL identity_counts: got timeout=%0d beats=%0d done=%0d want 0/12/1", timeout_hit, nbeats, ndone);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if ({bx[i], by[i], bu[i], bv[i], boob[i]} !== {10'(i % H), 10'(i / H), 16'(i % H), 16'(i / H), 1'b0}) begin
        failures++;
        $display("FAIL identity_beat%0d: got x=%0d y=%0d u=%0d v=%0d oob=%0d want %0d,%0d,%0d,%0d,0",
                 i, bx[i], by[i], bu[i], bv[i], boob[i], i % H, i / H, i % H, i / H);
      end
    end
  endtask

  task automatic test_offset_scale;
    // offsetx = 10.0, scalex = 2.0; inputs scrambled after acceptance must not matter
    set_params(24'h000A00, 24'd0, 24'd0, 24'd0, 24'h004000, 24'h004000, 24'h000200, 24'h000100, 24'd0);
    run_frame(-1, -1, 0, -1, -1, -1, 1'b1);
    checks++;
    if (nbeats !== NPIX) begin
      failures++;
      $display("FAIL offset_beats: got %0d want 12", nbeats);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if ({bu[i], bv[i], boob[i]} !== {16'(20 + 2 * (i % H)), 16'(i / H), 1'b0}) begin
        failures++;
        $display("FAIL offset_beat%0d: got u=%0d v=%0d oob=%0d want u=%0d v=%0d oob=0",
                 i, bu[i], bv[i], boob[i], 20 + 2 * (i % H), i / H);
      end
    end
  endtask

  task automatic test_rot90;
    // 90 degrees: U = y, V = -x per pixel; negative V wraps to 64-x and is out of bounds
    set_params(24'd0, 24'd0, 24'd0, 24'd0, 24'h004000, 24'h004000, 24'h000100, 24'h000100, 24'h004000);
    run_frame(-1, -1, 0, -1, -1, -1, 1'b0);
    checks++;
    if ({bu[1], bv[1], boob[1]} !== {16'd0, 16'd63, 1'b1}) begin
      failures++;
      $display("FAIL rot90_px1_0: got u=%0d v=%0d oob=%0d want 0,63,1", bu[1], bv[1], boob[1]);
    end
    checks++;
    if ({bu[8], bv[8], boob[8]} !== {16'd2, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL rot90_px0_2: got u=%0d v=%0d oob=%0d want 2,0,0", bu[8], bv[8], boob[8]);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if ({bu[i], bv[i], boob[i]} !== {16'(i / H), 16'((64 - (i % H)) % 64), (i % H) != 0}) begin
        failures++;
        $display("FAIL rot90_beat%0d: got u=%0d v=%0d oob=%0d want %0d,%0d,%0d",
                 i, bu[i], bv[i], boob[i], i / H, (64 - (i % H)) % 64, (i % H) != 0);
      end
    end
  endtask

  task automatic test_backpressure;
    set_params(24'd0, 24'd0, 24'd0, 24'd0, 24'h004000, 24'h004000, 24'h000100, 24'h000100, 24'd0);
    run_frame(2, 1, 3, -1, -1, -1, 1'b0);
    checks++;
    if (stall_seen !== 3 || stall_bad !== 0) begin
      failures++;
      $display("FAIL stall_stable: got stalls=%0d unstable=%0d want 3/0", stall_seen, stall_bad);
    end
    checks++;
    if (nbeats !== NPIX || bcyc[6] !== 16 || bcyc[7] !== 17) begin
      failures++;
      $display("FAIL stall_timing: got beats=%0d cyc6=%0d cyc7=%0d want 12/16/17", nbeats, bcyc[6], bcyc[7]);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if ({bx[i], by[i], bu[i], bv[i]} !== {10'(i % H), 10'(i / H), 16'(i % H), 16'(i / H)}) begin
        failures++;
        $display("FAIL stall_beat%0d: got x=%0d y=%0d u=%0d v=%0d want %0d,%0d,%0d,%0d",
                 i, bx[i], by[i], bu[i], bv[i], i % H, i / H, i % H, i / H);
      end
    end
  endtask

  task automatic test_timing;
    set_params(24'd0, 24'd0, 24'd0, 24'd0, 24'h004000, 24'h004000, 24'h000100, 24'h000100, 24'd0);
    run_frame(-1, -1, 0, 7, -1, -1, 1'b0);
    checks++;
    if (busy_first !== 1'b1 || first_valid_cyc !== 5) begin
      failures++;
      $display("FAIL latency: got busy=%0d first_valid=%0d want 1/5", busy_first, first_valid_cyc);
    end
    checks++;
    if (bcyc[0] !== 5 || bcyc[3] !== 8 || bcyc[4] !== 11 || bcyc[8] !== 17 || bcyc[11] !== 20) begin
      failures++;
      $display("FAIL line_gap: got %0d %0d %0d %0d %0d want 5 8 11 17 20", bcyc[0], bcyc[3], bcyc[4], bcyc[8], bcyc[11]);
    end
    checks++;
    if (done_cyc !== 21 || busy_at_done !== 1'b0 || valid_at_done !== 1'b0 || ndone !== 1) begin
      failures++;
      $display("FAIL frame_end: got done_cyc=%0d busy=%0d valid=%0d ndone=%0d want 21/0/0/1",
               done_cyc, busy_at_done, valid_at_done, ndone);
    end
    checks++;
    if (nbeats !== NPIX) begin
      failures++;
      $display("FAIL retrigger_ignored: got beats=%0d want 12", nbeats);
    end
  endtask

  task automatic test_reset_midframe;
    set_params(24'd0, 24'd0, 24'd0, 24'd0, 24'h004000, 24'h004000, 24'h000100, 24'h000100, 24'd0);
    run_frame(-1, -1, 0, -1, 1, 1, 1'b0);
    checks++;
    if (rst_hit !== 1'b1 || rst_vec !== 56'd0) begin
      failures++;
      $display("FAIL midframe_reset: got hit=%0d outs=%h want 1/0", rst_hit, rst_vec);
    end
    checks++;
    if (ndone !== 0 || nbeats !== 5) begin
      failures++;
      $display("FAIL midframe_no_done: got done=%0d beats=%0d want 0/5", ndone, nbeats);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(-1, -1, 0, -1, -1, -1, 1'b0);
    checks++;
    if (nbeats !== NPIX || ndone !== 1) begin
      failures++;
      $display("FAIL after_reset_counts: got beats=%0d done=%0d want 12/1", nbeats, ndone);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if ({bx[i], by[i], bu[i], bv[i], boob[i]} !== {10'(i % H), 10'(i / H), 16'(i % H), 16'(i / H), 1'b0}) begin
        failures++;
        $display("FAIL after_reset_beat%0d: got x=%0d y=%0d u=%0d v=%0d oob=%0d", i, bx[i], by[i], bu[i], bv[i], boob[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_offset_scale();
    test_rot90();
    test_backpressure();
    test_timing();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
